datapath: RTL and testbench

- 32-bit single-bus processor datapath for the multi-cycle CPU; the control unit (or a bench) drives every strobe directly.
- Contains the register file, PC, IR, MAR, MDR, Y, 64-bit Z, HI and LO registers, the ALU, the select-encode and C sign-extend logic, the CON branch flip-flop, I/O ports and a 512x32 RAM.
- All transfers go over one 32-bit bus.

---
 rtl/datapath_pkg.sv | 67 ++++++
 rtl/datapath_alu.sv | 57 +++++
 rtl/datapath.sv | 167 ++++++++++++++++
 tb/tb_datapath.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: opcodes, branch
// condition codes, the ALU operation enum and the opcode-to-ALU decode.
package datapath_pkg;

    localparam int DW       = 32;
    localparam int NUM_REGS = 16;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10100;

    localparam logic [1:0] BRZR = 2'b00;
    localparam logic [1:0] BRNZ = 2'b01;
    localparam logic [1:0] BRPL = 2'b10;
    localparam logic [1:0] BRMI = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SHR, ALU_SHL, ALU_ROR, ALU_ROL, ALU_AND,
        ALU_OR, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT, ALU_PASSB
    } alu_op_e;

    // Address arithmetic (loads, stores, branches, jal) shares the adder.
    function automatic alu_op_e decode_op(input logic [4:0] opc);
        case (opc)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BR, OP_JAL: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_SHR:          return ALU_SHR;
            OP_SHL:          return ALU_SHL;
            OP_ROR:          return ALU_ROR;
            OP_ROL:          return ALU_ROL;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            OP_NEG:          return ALU_NEG;
            OP_NOT:          return ALU_NOT;
            default:         return ALU_PASSB;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [1:0] c2, input logic [DW-1:0] v);
        case (c2)
            BRZR:    return (v == '0);
            BRNZ:    return (v != '0);
            BRPL:    return ~v[DW-1];
            default: return v[DW-1];
        endcase
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 32x32 -> 64 ALU. A is the Y register, B is the bus.
// High word is only non-zero for mul (product) and div (remainder).
module datapath_alu
    import datapath_pkg::*;
(
    input  alu_op_e          op,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [2*DW-1:0]  result
);

    logic [4:0]             amt;
    logic [5:0]             amt_inv;
    logic signed [2*DW-1:0] a_ext, b_ext, prod;
    logic [DW-1:0]          mag_a, mag_b, q_mag, r_mag, quo, rem;

    assign amt     = b[4:0];
    assign amt_inv = 6'd32 - {1'b0, amt};
    assign a_ext   = {{DW{a[DW-1]}}, a};
    assign b_ext   = {{DW{b[DW-1]}}, b};
    assign prod    = a_ext * b_ext;

    // Signed divide done on magnitudes so -2^31 / -1 wraps instead of trapping.
    always_comb begin
        mag_a = a[DW-1] ? -a : a;
        mag_b = b[DW-1] ? -b : b;
        q_mag = '0;
        r_mag = '0;
        if (b != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quo = (a[DW-1] ^ b[DW-1]) ? -q_mag : q_mag;
        rem = a[DW-1] ? -r_mag : r_mag;
    end

    // Operation select; shift by 32 yields 0 so rotate by 0 is the identity.
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result[DW-1:0] = a + b;
            ALU_SUB: result[DW-1:0] = a - b;
            ALU_SHR: result[DW-1:0] = a >> amt;
            ALU_SHL: result[DW-1:0] = a << amt;
            ALU_ROR: result[DW-1:0] = (a >> amt) | (a << amt_inv);
            ALU_ROL: result[DW-1:0] = (a << amt) | (a >> amt_inv);
            ALU_AND: result[DW-1:0] = a & b;
            ALU_OR:  result[DW-1:0] = a | b;
            ALU_MUL: result = prod;
            ALU_DIV: result = {rem, quo};
            ALU_NEG: result[DW-1:0] = -b;
            ALU_NOT: result[DW-1:0] = ~b;
            default: result[DW-1:0] = b;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file, PC/IR/MAR/MDR/Y/Z/HI/LO,
// CON flip-flop, I/O ports and memory. Every strobe comes from outside.
// Build option DATAPATH_EXT_MEM_EN: when defined, the internal RAM is
// removed and memory read data comes from Mdatain (RAMin is ignored).
module datapath
    import datapath_pkg::*;
#(
    parameter int RAM_DEPTH = 512
) (
    input  logic                    Clock,
    input  logic                    Clear,
    input  logic                    PCout, ZLowout, ZHighout, MDRout, HIout,
    input  logic                    LOout, Cout, InPortOut, BAout, Rout,
    input  logic                    MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin,
    input  logic                    PCin, IRin, Yin, CONin, Rin, OutPortIn,
    input  logic                    InPortIn,
    input  logic                    RAMin,
    input  logic                    IncPC,
    input  logic                    Read,
    input  logic                    GRA, GRB, GRC,
    input  logic [NUM_REGS-1:0]     REGin,
    input  logic [NUM_REGS-1:0]     REGout,
    output logic [4:0]              opcode,
    input  logic [DW-1:0]           Mdatain,
    input  logic [DW-1:0]           InPort_data,
    output logic [DW-1:0]           OutPort_data,
    output logic [DW-1:0]           bus
);

    localparam int AW = $clog2(RAM_DEPTH);

    logic [NUM_REGS-1:0][DW-1:0] r_q, r_d;
    logic [DW-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [DW-1:0] y_q, y_d, z_lo_q, z_lo_d, z_hi_q, z_hi_d;
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, in_port_q, in_port_d;
    logic [DW-1:0] out_port_q, out_port_d;
    logic          con_q, con_d;

    logic [3:0]          sel_fld;
    logic                sel_vld;
    logic [NUM_REGS-1:0] sel_oh;
    logic [DW-1:0]       c_sext, mem_rdata, reg_val;
    logic                reg_hit;
    logic [2*DW-1:0]     alu_res;

    assign opcode       = ir_q[31:27];
    assign OutPort_data = out_port_q;
    assign c_sext       = {{(DW-19){ir_q[18]}}, ir_q[18:0]};

    // Select-encode: pick Ra/Rb/Rc field (A over B over C) and one-hot it.
    always_comb begin
        sel_fld = 4'd0;
        if (GRA)      sel_fld = ir_q[26:23];
        else if (GRB) sel_fld = ir_q[22:19];
        else if (GRC) sel_fld = ir_q[18:15];
        sel_vld = GRA | GRB | GRC;
        sel_oh  = sel_vld ? (NUM_REGS'(1) << sel_fld) : '0;
    end

    // Bus source mux; fixed priority, lowest-numbered REGout wins among registers.
    always_comb begin
        reg_val = '0;
        reg_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (REGout[i] && !reg_hit) begin
                reg_val = r_q[i];
                reg_hit = 1'b1;
            end
        end
        bus = '0;
        if (ZLowout)        bus = z_lo_q;
        else if (ZHighout)  bus = z_hi_q;
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Cout)      bus = c_sext;
        else if (InPortOut) bus = in_port_q;
        else if (reg_hit)   bus = reg_val;
        else if (sel_vld && (Rout || BAout))
            bus = (BAout && sel_fld == 4'd0) ? '0 : r_q[sel_fld];
    end

    datapath_alu u_alu (
        .op     (decode_op(ir_q[31:27])),
        .a      (y_q),
        .b      (bus),
        .result (alu_res)
    );

`ifdef DATAPATH_EXT_MEM_EN
    logic unused_mem;
    assign mem_rdata  = Mdatain;
    assign unused_mem = ^{RAMin, mar_q};
`else
    logic [DW-1:0] ram_q [RAM_DEPTH];
    logic [AW-1:0] ram_addr;
    logic          unused_mem;
    assign ram_addr   = mar_q[AW-1:0];
    assign mem_rdata  = ram_q[ram_addr];
    assign unused_mem = ^{Mdatain, mar_q[DW-1:AW]};

    // RAM write port; contents survive Clear.
    always_ff @(posedge Clock) begin
        if (RAMin) ram_q[ram_addr] <= mdr_q;
    end
`endif

    // Next-state for every bus-loaded register.
    always_comb begin
        r_d = r_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (REGin[i] || (Rin && sel_oh[i])) r_d[i] = bus;
        end
        pc_d = pc_q;
        if (PCin) begin
            if (IncPC)                          pc_d = pc_q + 32'd1;
            else if (!(opcode == OP_BR && !con_q)) pc_d = bus;
        end
        mdr_d = mdr_q;
        if (MDRin) mdr_d = Read ? mem_rdata : bus;
        ir_d       = IRin      ? bus : ir_q;
        mar_d      = MARin     ? bus : mar_q;
        y_d        = Yin       ? bus : y_q;
        hi_d       = HIin      ? bus : hi_q;
        lo_d       = LOin      ? bus : lo_q;
        out_port_d = OutPortIn ? bus : out_port_q;
        in_port_d  = InPortIn  ? InPort_data : in_port_q;
        z_lo_d     = ZLowIn    ? alu_res[DW-1:0]    : z_lo_q;
        z_hi_d     = ZHighIn   ? alu_res[2*DW-1:DW] : z_hi_q;
        con_d      = CONin     ? branch_cond(ir_q[20:19], bus) : con_q;
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_q        <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            y_q        <= '0;
            z_lo_q     <= '0;
            z_hi_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            con_q      <= 1'b0;
            in_port_q  <= '0;
            out_port_q <= '0;
        end else begin
            r_q        <= r_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            y_q        <= y_d;
            z_lo_q     <= z_lo_d;
            z_hi_q     <= z_hi_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            con_q      <= con_d;
            in_port_q  <= in_port_d;
            out_port_q <= out_port_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed ALU table, randomized ALU/register/memory
// traffic against a plain-arithmetic model, and hand-written fetch/branch/
// clear sequences.
module tb_datapath;

    logic Clock = 1'b0, Clear = 1'b0;
    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout;
    logic MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin, PCin, IRin, Yin, CONin, Rin;
    logic OutPortIn, InPortIn, RAMin, IncPC, Read, GRA, GRB, GRC;
    logic [15:0] REGin, REGout;
    logic [4:0]  opcode;
    logic [31:0] Mdatain, InPort_data, OutPort_data, bus;

    int checks = 0;
    int failures = 0;

    datapath dut (
        .Clock(Clock), .Clear(Clear),
        .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortOut(InPortOut),
        .BAout(BAout), .Rout(Rout),
        .MDRin(MDRin), .MARin(MARin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
        .CONin(CONin), .Rin(Rin), .OutPortIn(OutPortIn), .InPortIn(InPortIn),
        .RAMin(RAMin), .IncPC(IncPC), .Read(Read),
        .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .REGin(REGin), .REGout(REGout), .opcode(opcode),
        .Mdatain(Mdatain), .InPort_data(InPort_data),
        .OutPort_data(OutPort_data), .bus(bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a, b, lo, hi;
    } alu_vec_t;

    task automatic clr_ctl();
        {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut, BAout, Rout} = '0;
        {MDRin, MARin, ZLowIn, ZHighIn, HIin, LOin, PCin, IRin, Yin, CONin, Rin} = '0;
        {OutPortIn, InPortIn, RAMin, IncPC, Read, GRA, GRB, GRC} = '0;
        REGin = '0;
        REGout = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latch v into InPort, then leave InPortOut asserted so the caller's
    // load strobe picks it off the bus on the next edge.
    task automatic put(input logic [31:0] v);
        clr_ctl();
        InPort_data = v;
        InPortIn = 1'b1;
        tick();
        InPortIn = 1'b0;
        InPortOut = 1'b1;
    endtask

    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi);
        put({op, 27'd0}); IRin = 1'b1; tick();
        put(a); Yin = 1'b1; tick();
        put(b); ZLowIn = 1'b1; ZHighIn = 1'b1; tick();
        clr_ctl();
        ZLowout = 1'b1; #1; lo = bus;
        ZLowout = 1'b0; ZHighout = 1'b1; #1; hi = bus;
        clr_ctl();
    endtask

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [63:0] ref_alu(input logic [4:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        logic [31:0] r;
        int n;
        n  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = a;
        case (opc)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18, 5'd20: return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a / (32'd1 << n)};
            5'd6:  return {32'd0, a * (32'd1 << n)};
            5'd7:  begin for (int k = 0; k < n; k++) r = {r[0], r[31:1]}; return {32'd0, r}; end
            5'd8:  begin for (int k = 0; k < n; k++) r = {r[30:0], r[31]}; return {32'd0, r}; end
            5'd9, 5'd12:  return {32'd0, a & b};
            5'd10, 5'd13: return {32'd0, a | b};
            5'd14: return 64'(sa * sb);
            5'd15: begin
                if (sb == 0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            5'd16: return {32'd0, -b};
            5'd17: return {32'd0, ~b};
            default: return {32'd0, b};
        endcase
    endfunction

    alu_vec_t    vecs[16];
    logic [31:0] rmodel[16];
    logic [31:0] mem_m[int];
    logic [31:0] lo, hi, a, b, v;
    logic [4:0]  op;
    logic [63:0] exp64;
    int          idx;

    initial begin
        vecs[0]  = '{"add",      5'b00011, 32'd5,        32'd7,        32'd12,       32'd0};
        vecs[1]  = '{"add_wrap", 5'b00011, 32'hFFFFFFFF, 32'd2,        32'd1,        32'd0};
        vecs[2]  = '{"sub",      5'b00100, 32'd3,        32'd5,        32'hFFFFFFFE, 32'd0};
        vecs[3]  = '{"shr",      5'b00101, 32'h80000000, 32'd4,        32'h08000000, 32'd0};
        vecs[4]  = '{"shl31",    5'b00110, 32'd1,        32'h3F,       32'h80000000, 32'd0};
        vecs[5]  = '{"ror",      5'b00111, 32'd1,        32'd1,        32'h80000000, 32'd0};
        vecs[6]  = '{"rol",      5'b01000, 32'h80000001, 32'd4,        32'h00000018, 32'd0};
        vecs[7]  = '{"andi",     5'b01100, 32'hF0F0,     32'hFF00,     32'hF000,     32'd0};
        vecs[8]  = '{"ori",      5'b01101, 32'hF0F0,     32'h0F0F,     32'hFFFF,     32'd0};
        vecs[9]  = '{"mul",      5'b01110, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 32'hFFFFFFFF};
        vecs[10] = '{"div",      5'b01111, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[11] = '{"div_neg",  5'b01111, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[12] = '{"div0",     5'b01111, 32'd9,        32'd0,        32'd0,        32'd0};
        vecs[13] = '{"neg",      5'b10000, 32'd77,       32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[14] = '{"not",      5'b10001, 32'd77,       32'd0,        32'hFFFFFFFF, 32'd0};
        vecs[15] = '{"pass",     5'b10011, 32'd77,       32'h1234,     32'h1234,     32'd0};

        clr_ctl();
        InPort_data = '0;
        Mdatain = '0;
        #12;
        chk("rst_pc",  {32'd0, bus}, 64'd0);
        PCout = 1'b1; #1; chk("rst_pc", {32'd0, bus}, 64'd0); PCout = 1'b0;
        Clear = 1'b1;
        tick();
        ZLowout = 1'b1; #1; chk("rst_z", {32'd0, bus}, 64'd0); clr_ctl();
        MDRout = 1'b1;  #1; chk("rst_mdr", {32'd0, bus}, 64'd0); clr_ctl();
        chk("rst_opcode", {59'd0, opcode}, 64'd0);
        chk("rst_outport", {32'd0, OutPort_data}, 64'd0);

        // Directed ALU table.
        for (int i = 0; i < 16; i++) begin
            alu_run(vecs[i].op, vecs[i].a, vecs[i].b, lo, hi);
            chk({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].lo});
            chk({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].hi});
        end

        // Randomized ALU against the model.
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            alu_run(op, a, b, lo, hi);
            exp64 = ref_alu(op, a, b);
            chk("rand_alu", {hi, lo}, exp64);
        end

        // Randomized register file traffic through REGin/REGout.
        for (int i = 0; i < 16; i++) rmodel[i] = '0;
        for (int i = 0; i < 48; i++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom;
                put(v); REGin[idx] = 1'b1; tick(); clr_ctl();
                rmodel[idx] = v;
            end else begin
                clr_ctl(); REGout[idx] = 1'b1; #1;
                chk("rand_reg", {32'd0, bus}, {32'd0, rmodel[idx]});
                clr_ctl();
            end
        end
        // Same register loaded and driven at once keeps its value.
        REGin[4] = 1'b1; REGout[4] = 1'b1; tick(); clr_ctl();
        REGout[4] = 1'b1; #1; chk("reg_self_load", {32'd0, bus}, {32'd0, rmodel[4]}); clr_ctl();
        // Two REGout bits: lower index wins.
        REGout[9] = 1'b1; REGout[2] = 1'b1; #1;
        chk("reg_prio", {32'd0, bus}, {32'd0, rmodel[2]}); clr_ctl();

        // Select-encode: Rb=5 via GRB+Rin, then BAout with Rb=R0.
        put(32'h00280000); IRin = 1'b1; tick();
        put(32'h55); GRB = 1'b1; Rin = 1'b1; tick(); clr_ctl();
        REGout[5] = 1'b1; #1; chk("grb_rin", {32'd0, bus}, 64'h55); clr_ctl();
        GRB = 1'b1; BAout = 1'b1; #1; chk("baout_r5", {32'd0, bus}, 64'h55); clr_ctl();
        put(32'd5); REGin[0] = 1'b1; tick();
        put(32'h0); IRin = 1'b1; tick(); clr_ctl();
        GRB = 1'b1; BAout = 1'b1; #1; chk("baout_r0", {32'd0, bus}, 64'd0); clr_ctl();
        GRB = 1'b1; Rout = 1'b1; #1; chk("rout_r0", {32'd0, bus}, 64'd5); clr_ctl();

        // C sign extension, HI/LO, OutPort, priority, idle bus.
        put(32'h00040000); IRin = 1'b1; tick(); clr_ctl();
        Cout = 1'b1; #1; chk("c_sext", {32'd0, bus}, 64'hFFFC0000); clr_ctl();
        put(32'h1111); HIin = 1'b1; tick();
        put(32'h2222); LOin = 1'b1; tick(); clr_ctl();
        HIout = 1'b1; LOout = 1'b1; #1; chk("hi_over_lo", {32'd0, bus}, 64'h1111); clr_ctl();
        LOout = 1'b1; #1; chk("lo", {32'd0, bus}, 64'h2222); clr_ctl();
        put(32'hA5); OutPortIn = 1'b1; tick(); clr_ctl();
        chk("outport", {32'd0, OutPort_data}, 64'hA5);
        alu_run(5'b00011, 32'd3, 32'd4, lo, hi);
        put(32'hDEAD); ZLowout = 1'b1; #1; chk("zlow_over_inport", {32'd0, bus}, 64'd7); clr_ctl();
        #1; chk("bus_idle", {32'd0, bus}, 64'd0);

`ifndef DATAPATH_EXT_MEM_EN
        // Internal RAM write/read-back through MAR/MDR.
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 511);
            v = $urandom;
            put(32'(idx)); MARin = 1'b1; tick();
            put(v); MDRin = 1'b1; tick(); clr_ctl();
            RAMin = 1'b1; tick(); clr_ctl();
            mem_m[idx] = v;
        end
        foreach (mem_m[k]) begin
            put(32'(k)); MARin = 1'b1; tick(); clr_ctl();
            Read = 1'b1; MDRin = 1'b1; tick(); clr_ctl();
            MDRout = 1'b1; #1; chk("ram_rd", {32'd0, bus}, {32'd0, mem_m[k]}); clr_ctl();
            Read = 1'b1; tick(); clr_ctl();
            MDRout = 1'b1; #1; chk("read_no_mdrin", {32'd0, bus}, {32'd0, mem_m[k]}); clr_ctl();
        end
`endif

        // Clear mid-operation: PC=7, IR and Z non-zero, all read 0 before the edge.
        alu_run(5'b00011, 32'd3, 32'd4, lo, hi);
        put(32'h12345678); IRin = 1'b1; tick();
        put(32'd7); PCin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; #1; chk("pc_pre_clear", {32'd0, bus}, 64'd7); clr_ctl();
        Clear = 1'b0; #1;
        chk("clr_opcode", {59'd0, opcode}, 64'd0);
        PCout = 1'b1; #1; chk("clr_pc", {32'd0, bus}, 64'd0); PCout = 1'b0;
        ZLowout = 1'b1; #1; chk("clr_z", {32'd0, bus}, 64'd0); ZLowout = 1'b0;
        Cout = 1'b1; #1; chk("clr_ir", {32'd0, bus}, 64'd0); Cout = 1'b0;
        Clear = 1'b1;
        tick();

        // Instruction fetch from address 0.
        Mdatain = 32'h90800023;
        put(32'h90800023); MDRin = 1'b1; tick(); clr_ctl();
        RAMin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; MARin = 1'b1; tick(); clr_ctl();
        Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; tick(); clr_ctl();
        MDRout = 1'b1; IRin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; #1; chk("fetch_pc", {32'd0, bus}, 64'd1); clr_ctl();
        chk("fetch_opcode", {59'd0, opcode}, 64'b10010);
        MDRout = 1'b1; #1; chk("fetch_ir", {32'd0, bus}, 64'h90800023); clr_ctl();

        // brzr with R1=0: taken, PC = 1 + 0x23.
        GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; Yin = 1'b1; tick(); clr_ctl();
        Cout = 1'b1; ZLowIn = 1'b1; tick(); clr_ctl();
        ZLowout = 1'b1; PCin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; #1; chk("brzr_taken_pc", {32'd0, bus}, 64'h24); clr_ctl();

        // brnz with R1=0: not taken, PC holds at 1.
        put(32'd1); PCin = 1'b1; tick();
        put(32'h90880023); IRin = 1'b1; tick(); clr_ctl();
        GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; Yin = 1'b1; tick(); clr_ctl();
        Cout = 1'b1; ZLowIn = 1'b1; tick(); clr_ctl();
        ZLowout = 1'b1; #1; chk("brnz_target", {32'd0, bus}, 64'h24);
        PCin = 1'b1; tick(); clr_ctl();
        PCout = 1'b1; #1; chk("brnz_not_taken_pc", {32'd0, bus}, 64'd1); clr_ctl();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
